// File: rtl/flash_raid_pkg.sv
// Shared definitions for the flash access arbiter slice: mode encodings,
// arbiter state encoding, default address width and flash index constants.
package flash_raid_pkg;

    localparam int ADDR_W_DEFAULT = 24;

    // control_reg[1:0] encodings; 2'b11 is reserved and routes like MODE_MAIN.
    localparam logic [1:0] MODE_MAIN      = 2'b00;
    localparam logic [1:0] MODE_SECONDARY = 2'b01;
    localparam logic [1:0] MODE_SHARE     = 2'b10;

    // Flash device indices (bit position in flash_cs_n).
    localparam logic FLASH_MAIN = 1'b0;
    localparam logic FLASH_SEC  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DECODE  = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/flash_range_decoder.sv
// Combinational routing: picks the target flash for one address from the
// mode bits and the two inclusive address ranges (range0 wins on overlap).
module flash_range_decoder
    import flash_raid_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] range0_start,
    input  logic [ADDR_W-1:0] range0_end,
    input  logic              range0_enable,
    input  logic              range0_flash_select,
    input  logic [ADDR_W-1:0] range1_start,
    input  logic [ADDR_W-1:0] range1_end,
    input  logic              range1_enable,
    input  logic              range1_flash_select,
    output logic              flash_sel
);

    logic r0_hit;
    logic r1_hit;

    // Unsigned inclusive range hits; a range with start > end can never hit.
    always_comb begin
        r0_hit = range0_enable && (addr >= range0_start) && (addr <= range0_end);
        r1_hit = range1_enable && (addr >= range1_start) && (addr <= range1_end);
    end

    // Mode selects fixed routing or range-based sharing; default is the main flash.
    always_comb begin
        flash_sel = FLASH_MAIN;
        case (mode)
            MODE_SECONDARY: flash_sel = FLASH_SEC;
            MODE_SHARE: begin
                if (r0_hit)      flash_sel = range0_flash_select;
                else if (r1_hit) flash_sel = range1_flash_select;
                else             flash_sel = FLASH_MAIN;
            end
            default:        flash_sel = FLASH_MAIN;
        endcase
    end

endmodule

// File: rtl/flash_access_arbiter.sv
// Arbitrates two hosts onto two SPI flash devices: IDLE -> DECODE -> ACTIVE
// -> RELEASE. Routing is decided once in DECODE; grant/CS are registered and
// first appear two edges after the request is sampled.
// Handshake: host_req is a level held by the host until its transaction ends;
// the transaction ends on a one-cycle host_done pulse from the granted host or
// when the granted host drops host_req; RELEASE always gives one deselected cycle.
// Optional macro FLASH_ARB_WATCHDOG_EN adds an ACTIVE-state watchdog that forces
// RELEASE after TIMEOUT_CYCLES cycles and sets the sticky timeout_err flag.
module flash_access_arbiter
    import flash_raid_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        host_req,
    input  logic [ADDR_W-1:0] host_addr0,
    input  logic [ADDR_W-1:0] host_addr1,
    input  logic [1:0]        host_done,
    input  logic [1:0]        cfg_mode,
    input  logic              cfg_host_select,
    input  logic [ADDR_W-1:0] range0_start,
    input  logic [ADDR_W-1:0] range0_end,
    input  logic [ADDR_W-1:0] range1_start,
    input  logic [ADDR_W-1:0] range1_end,
    input  logic              range0_enable,
    input  logic              range0_flash_select,
    input  logic              range1_enable,
    input  logic              range1_flash_select,
    input  logic              clr_err,
    output logic [1:0]        host_gnt,
    output logic [1:0]        flash_cs_n,
    output logic              active_flash,
    output logic              busy,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  txn_count,
    output logic [1:0]        state_dbg
);

    arb_state_t        state_q, state_d;
    logic              host_q, host_d;
    logic              flash_q, flash_d;
    logic              dec_flash;
    logic [ADDR_W-1:0] dec_addr;
    logic              done_exit;
    logic              drop_exit;
    logic              timeout_hit;
    logic [1:0]        gnt_q;
    logic [1:0]        cs_n_q;
    logic              busy_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;

    assign dec_addr  = host_q ? host_addr1 : host_addr0;
    assign done_exit = (state_q == ST_ACTIVE) && host_done[host_q];
    assign drop_exit = (state_q == ST_ACTIVE) && !host_req[host_q];

    flash_range_decoder #(.ADDR_W(ADDR_W)) u_decoder (
        .addr                (dec_addr),
        .mode                (cfg_mode),
        .range0_start        (range0_start),
        .range0_end          (range0_end),
        .range0_enable       (range0_enable),
        .range0_flash_select (range0_flash_select),
        .range1_start        (range1_start),
        .range1_end          (range1_end),
        .range1_enable       (range1_enable),
        .range1_flash_select (range1_flash_select),
        .flash_sel           (dec_flash)
    );

`ifdef FLASH_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q;

    // Watchdog counts ACTIVE cycles; it reads zero on every ACTIVE entry.
    always_ff @(posedge clk) begin
        if (rst || state_q != ST_ACTIVE) wd_q <= '0;
        else                             wd_q <= wd_q + 1'b1;
    end

    // A normal exit in the same cycle takes precedence over the timeout.
    assign timeout_hit = (state_q == ST_ACTIVE) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1))
                         && !done_exit && !drop_exit;

    // Sticky error: a new timeout beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst)              err_q <= 1'b0;
        else if (timeout_hit) err_q <= 1'b1;
        else if (clr_err)     err_q <= 1'b0;
    end
`else
    logic unused_wd_cfg;
    assign unused_wd_cfg = clr_err ^ (TIMEOUT_CYCLES != 0);
    assign timeout_hit   = 1'b0;
    assign err_q         = 1'b0;
`endif

    // State, chosen host and latched target flash.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            host_q  <= 1'b0;
            flash_q <= FLASH_MAIN;
        end else begin
            state_q <= state_d;
            host_q  <= host_d;
            flash_q <= flash_d;
        end
    end

    // Next-state logic: arbitration in IDLE, routing decision in DECODE.
    always_comb begin
        state_d = state_q;
        host_d  = host_q;
        flash_d = flash_q;
        case (state_q)
            ST_IDLE: begin
                if (|host_req) begin
                    state_d = ST_DECODE;
                    host_d  = (&host_req) ? cfg_host_select : host_req[1];
                end
            end
            ST_DECODE: begin
                if (!host_req[host_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACTIVE;
                    flash_d = dec_flash;
                end
            end
            ST_ACTIVE: begin
                if (done_exit || drop_exit || timeout_hit) state_d = ST_RELEASE;
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Registered outputs; grant/CS held only while ACTIVE continues, which
    // delays them one cycle after ACTIVE entry and drops them on exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q  <= 2'b00;
            cs_n_q <= 2'b11;
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (state_q == ST_ACTIVE && state_d == ST_ACTIVE) begin
                gnt_q  <= host_q  ? 2'b10 : 2'b01;
                cs_n_q <= flash_q ? 2'b01 : 2'b10;
            end else begin
                gnt_q  <= 2'b00;
                cs_n_q <= 2'b11;
            end
            busy_q <= (state_d != ST_IDLE);
            if (done_exit && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign host_gnt     = gnt_q;
    assign flash_cs_n   = cs_n_q;
    assign active_flash = flash_q;
    assign busy         = busy_q;
    assign timeout_err  = err_q;
    assign txn_count    = cnt_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_flash_access_arbiter.sv
// Self-checking bench for flash_access_arbiter: directed scenarios followed by
// randomized transactions checked against a transaction-level reference model.
module tb_flash_access_arbiter;

    localparam int AW = 24;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    host_req;
    logic [AW-1:0] host_addr0, host_addr1;
    logic [1:0]    host_done;
    logic [1:0]    cfg_mode;
    logic          cfg_host_select;
    logic [AW-1:0] range0_start, range0_end, range1_start, range1_end;
    logic          range0_enable, range0_flash_select, range1_enable, range1_flash_select;
    logic          clr_err;
    logic [1:0]    host_gnt, flash_cs_n, state_dbg;
    logic          active_flash, busy, timeout_err;
    logic [CW-1:0] txn_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [CW-1:0] exp_cnt;
    logic [3:0]    exp_q[$];

    flash_access_arbiter #(.ADDR_W(AW), .TIMEOUT_CYCLES(16), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .host_req(host_req),
        .host_addr0(host_addr0), .host_addr1(host_addr1), .host_done(host_done),
        .cfg_mode(cfg_mode), .cfg_host_select(cfg_host_select),
        .range0_start(range0_start), .range0_end(range0_end),
        .range1_start(range1_start), .range1_end(range1_end),
        .range0_enable(range0_enable), .range0_flash_select(range0_flash_select),
        .range1_enable(range1_enable), .range1_flash_select(range1_flash_select),
        .clr_err(clr_err), .host_gnt(host_gnt), .flash_cs_n(flash_cs_n),
        .active_flash(active_flash), .busy(busy), .timeout_err(timeout_err),
        .txn_count(txn_count), .state_dbg(state_dbg)
    );

    // Clock and global time limit.
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL time_limit got=running exp=finished");
        $fatal(1, "time limit");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference routing: straight from the mode/range rules.
    function automatic logic model_flash(input logic [AW-1:0] a);
        if (cfg_mode == 2'b01) return 1'b1;
        if (cfg_mode != 2'b10) return 1'b0;
        if (range0_enable && range0_start <= a && a <= range0_end) return range0_flash_select;
        if (range1_enable && range1_start <= a && a <= range1_end) return range1_flash_select;
        return 1'b0;
    endfunction

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return range0_start;
            1:       return range0_end;
            2:       return range0_start - 1'b1;
            3:       return range0_end + 1'b1;
            4:       return range1_start;
            default: return AW'($urandom);
        endcase
    endfunction

    task automatic rand_range(output logic [AW-1:0] s, output logic [AW-1:0] e);
        s = AW'($urandom);
        if ($urandom_range(0, 4) == 0) e = s - AW'($urandom_range(1, 255));
        else                           e = s + AW'($urandom_range(0, 24'h0FFFFF));
    endtask

    // One transaction starting from IDLE at a falling edge; host_req already
    // holds every requesting host. Ends by done pulse or by req drop.
    task automatic run_txn(input bit by_done, input int hold, input bit flip_mode);
        logic w, ef;
        logic [3:0] exp;
        w  = (host_req == 2'b11) ? cfg_host_select : host_req[1];
        ef = model_flash(w ? host_addr1 : host_addr0);
        exp_q.push_back({(w ? 2'b10 : 2'b01), (ef ? 2'b01 : 2'b10)});
        @(negedge clk);
        check_eq("busy_decode", busy, 1);
        check_eq("gnt_decode", host_gnt, 0);
        @(negedge clk);
        check_eq("gnt_first_active", host_gnt, 0);
        check_eq("active_flash", active_flash, ef);
        if (flip_mode) cfg_mode = (cfg_mode == 2'b01) ? 2'b00 : 2'b01;
        @(negedge clk);
        exp = exp_q.pop_front();
        check_eq("gnt_cs", {host_gnt, flash_cs_n}, exp);
        for (int i = 0; i < hold; i++) begin
            if ($urandom_range(0, 2) == 0) host_done[~w] = 1'b1;
            @(negedge clk);
            host_done = 2'b00;
            check_eq("gnt_cs_hold", {host_gnt, flash_cs_n}, exp);
        end
        if (by_done) begin
            host_done[w] = 1'b1;
            if (exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        end
        host_req[w] = 1'b0;
        @(negedge clk);
        host_done = 2'b00;
        check_eq("release_gnt_cs", {host_gnt, flash_cs_n}, 4'b0011);
        check_eq("release_busy", busy, 1);
        check_eq("txn_count", txn_count, exp_cnt);
        @(negedge clk);
        check_eq("idle_busy", busy, 0);
    endtask

    initial begin
        logic [1:0] nr;
        int hi;
        rst = 1'b1; host_req = 2'b00; host_done = 2'b00; cfg_mode = 2'b00;
        cfg_host_select = 1'b0; host_addr0 = '0; host_addr1 = '0;
        range0_start = '0; range0_end = '0; range1_start = '0; range1_end = '0;
        range0_enable = 1'b0; range0_flash_select = 1'b0;
        range1_enable = 1'b0; range1_flash_select = 1'b0; clr_err = 1'b0;
        exp_cnt = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_gnt", host_gnt, 0);
        check_eq("rst_cs", flash_cs_n, 2'b11);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_flash", active_flash, 0);
        check_eq("rst_err", timeout_err, 0);
        check_eq("rst_cnt", txn_count, 0);
        check_eq("rst_state", state_dbg, 0);
        rst = 1'b0;

        // Basic main-host transaction to the main flash.
        host_addr0 = 24'h001000; host_req = 2'b01;
        run_txn(1, 2, 0);
        check_eq("first_count", txn_count, 1);

        // Share mode with range0 boundaries and an inverted range.
        cfg_mode = 2'b10; range0_start = 24'h100000; range0_end = 24'h1FFFFF;
        range0_enable = 1'b1; range0_flash_select = 1'b1;
        host_addr0 = 24'h100000; host_req = 2'b01; run_txn(1, 1, 0);
        host_addr0 = 24'h1FFFFF; host_req = 2'b01; run_txn(1, 0, 0);
        host_addr0 = 24'h200000; host_req = 2'b01; run_txn(1, 1, 0);
        range0_start = 24'h300000; range0_end = 24'h100000;
        host_addr0 = 24'h200000; host_req = 2'b01; run_txn(1, 1, 0);

        // Simultaneous requests, secondary preferred, then the main host.
        cfg_mode = 2'b00; cfg_host_select = 1'b1; host_req = 2'b11;
        run_txn(1, 2, 0);
        run_txn(1, 1, 0);

        // Mode change while ACTIVE is ignored until the next transaction.
        cfg_host_select = 1'b0; host_req = 2'b01;
        run_txn(1, 3, 1);
        host_req = 2'b01;
        run_txn(1, 1, 0);
        cfg_mode = 2'b00;

        // Chosen host drops req during DECODE: no grant.
        host_req = 2'b10;
        @(negedge clk);
        host_req = 2'b00;
        @(negedge clk);
        check_eq("drop_busy", busy, 0);
        check_eq("drop_gnt", host_gnt, 0);
        @(negedge clk);
        check_eq("drop_gnt2", {host_gnt, flash_cs_n}, 4'b0011);

        // Watchdog behaviour (or its absence).
`ifdef FLASH_ARB_WATCHDOG_EN
        host_req = 2'b01; host_addr0 = 24'h000010;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check_eq("wd_gnt", host_gnt, 2'b01);
        hi = 1;
        for (int i = 0; i < 40 && host_gnt != 2'b00; i++) begin
            @(negedge clk);
            if (host_gnt != 2'b00) hi++;
        end
        check_eq("wd_gnt_cycles", hi, 15);
        check_eq("wd_err", timeout_err, 1);
        check_eq("wd_cnt", txn_count, exp_cnt);
        check_eq("wd_cs", flash_cs_n, 2'b11);
        host_req = 2'b00; clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check_eq("wd_clr", timeout_err, 0);
        @(negedge clk);
`else
        hi = 0;
        host_req = 2'b01; host_addr0 = 24'h000010; clr_err = 1'b1;
        run_txn(1, 30, 0);
        clr_err = 1'b0;
        check_eq("no_wd_err", timeout_err, hi);
`endif

        // Reset during ACTIVE drops everything on the next edge.
        host_req = 2'b10; cfg_mode = 2'b01;
        repeat (3) @(negedge clk);
        check_eq("pre_rst_gnt", {host_gnt, flash_cs_n}, 4'b1001);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_gnt", host_gnt, 0);
        check_eq("mid_rst_cs", flash_cs_n, 2'b11);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_state", state_dbg, 0);
        check_eq("mid_rst_cnt", txn_count, 0);
        exp_cnt = '0; host_req = 2'b00; rst = 1'b0;
        @(negedge clk);

        // Randomized transactions; long enough to saturate the counter.
        for (int t = 0; t < 70; t++) begin
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_host_select = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                rand_range(range0_start, range0_end);
                rand_range(range1_start, range1_end);
                range0_enable = 1'($urandom_range(0, 1));
                range1_enable = 1'($urandom_range(0, 1));
                range0_flash_select = 1'($urandom_range(0, 1));
                range1_flash_select = 1'($urandom_range(0, 1));
            end
            host_addr0 = pick_addr();
            host_addr1 = pick_addr();
            nr = 2'($urandom_range(1, 3));
            host_req = host_req | nr;
            run_txn($urandom_range(0, 3) != 0, $urandom_range(0, 6), $urandom_range(0, 4) == 0);
        end
        check_eq("sat_count", txn_count, exp_cnt);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
